// File: rtl/stopwatch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | stopwatch_ctrl : start/stop/lap sequencer driving a 4-digit BCD SS.hh time  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int PRESC = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce1ms,
  input  logic        btn_start,
  input  logic        btn_lap,
  output logic [15:0] dat,
  output logic        running,
  output logic        lap_active,
  output logic        ovf
);

  localparam logic [3:0] c_PRESC_LAST = 4'(PRESC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_start_prev;
  logic        r_lap_prev;
  logic [3:0]  r_presc;
  logic [3:0]  w_presc_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [15:0] w_cnt_inc;
  logic [15:0] r_snap;
  logic [15:0] w_snap_nxt;
  logic [15:0] r_dat;
  logic        r_running;
  logic        r_lap_active;
  logic        r_ovf;
  logic        w_start_ev;
  logic        w_lap_ev;
  logic        w_counting;
  logic        w_tick;
  logic        w_wrap;

  // Start has priority: a simultaneous lap edge is discarded.
  assign w_start_ev = btn_start & ~r_start_prev;
  assign w_lap_ev   = btn_lap & ~r_lap_prev & ~w_start_ev;
  assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_tick     = w_counting && ce1ms && (r_presc == c_PRESC_LAST);

  always_comb begin : bcd_inc
    logic carry;
    carry     = 1'b1;
    w_cnt_inc = r_cnt;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r_cnt[4*i +: 4] == 4'd9) begin
          w_cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          w_cnt_inc[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    w_wrap = carry;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_presc_nxt = r_presc;
    w_snap_nxt  = r_snap;
    if (w_counting && ce1ms) begin
      w_presc_nxt = w_tick ? 4'd0 : r_presc + 4'd1;
    end
    if (w_tick) begin
      w_cnt_nxt = w_cnt_inc;
    end
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt   = '0;
        w_presc_nxt = '0;
        if (w_start_ev) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_start_ev) begin
          w_state_nxt = S_PAUSE;
        end else if (w_lap_ev) begin
          w_state_nxt = S_LAP;
          w_snap_nxt  = r_cnt;   // pre-increment value even on a tick cycle
        end
      end
      S_LAP: begin
        if (w_start_ev)    w_state_nxt = S_PAUSE;
        else if (w_lap_ev) w_state_nxt = S_RUN;
      end
      S_PAUSE: begin
        if (w_start_ev) begin
          w_state_nxt = S_RUN;
        end else if (w_lap_ev) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_presc_nxt = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Outputs are computed from next-state values so they are registered yet current.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_prev <= 1'b0;
      r_lap_prev   <= 1'b0;
      r_presc      <= '0;
      r_cnt        <= '0;
      r_snap       <= '0;
      r_dat        <= '0;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_start_prev <= btn_start;
      r_lap_prev   <= btn_lap;
      r_presc      <= w_presc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_snap       <= w_snap_nxt;
      r_dat        <= (w_state_nxt == S_LAP) ? w_snap_nxt : w_cnt_nxt;
      r_running    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP);
      r_lap_active <= (w_state_nxt == S_LAP);
      r_ovf        <= w_tick & w_wrap;
    end
  end

  assign dat        = r_dat;
  assign running    = r_running;
  assign lap_active = r_lap_active;
  assign ovf        = r_ovf;

endmodule
`default_nettype wire
